// File: rtl/issue_fifo_param.sv
// Parametrised issue FIFO between command scheduler and DRAM command port.
// Ports: clk, rst, flush, wen/data_in, ren/data_out, data_out_pre/pre_valid,
//   count, full, almost_full, empty, overflow, underflow.
//   Optional replay input when ISSUE_FIFO_REPLAY_EN is defined.
module issue_fifo_param #(
  parameter int WIDTH        = 21,
  parameter int DEPTH        = 32,
  parameter int FULL_MARGIN  = 4,
  parameter int AFULL_MARGIN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     ren,
`ifdef ISSUE_FIFO_REPLAY_EN
  input  logic                     replay,
`endif
  output logic [WIDTH-1:0]         data_out,
  output logic [WIDTH-1:0]         data_out_pre,
  output logic                     pre_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

`ifdef ISSUE_FIFO_REPLAY_EN
  // One slot is kept free so the previous entry survives for replay.
  localparam logic [PW-1:0] CAP = PW'(DEPTH - 1);
`else
  localparam logic [PW-1:0] CAP = PW'(DEPTH);
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_n, wr_n;
  logic [PW-1:0]    free, free_n;
  // Popped entries behind rd_ptr that are still intact in memory.
  logic [PW-1:0]    hist, hist_n, hist_sum;
  logic [AW-1:0]    rd_prev;
  logic             push_ok, pop_ok, replay_ok;
  logic             ovf_n, udf_n;

`ifdef ISSUE_FIFO_REPLAY_EN
  assign replay_ok = replay && pre_valid && !flush;
`else
  assign replay_ok = 1'b0;
`endif

  assign count       = wr_ptr - rd_ptr;
  assign free        = PW'(DEPTH) - count;
  assign empty       = (count == '0);
  assign full        = int'(free) < FULL_MARGIN;
  assign almost_full = int'(free) < AFULL_MARGIN;
  assign pre_valid   = (hist != '0);

  assign rd_prev      = rd_ptr[AW-1:0] - AW'(1);
  assign data_out     = mem[rd_ptr[AW-1:0]];
  assign data_out_pre = mem[rd_prev];

  assign push_ok = wen && (count < CAP) && !flush;
  assign pop_ok  = ren && !empty && !replay_ok && !flush;

  always_comb begin
    rd_n     = rd_ptr;
    wr_n     = wr_ptr;
    hist_sum = hist;
    hist_n   = hist;
    ovf_n    = overflow;
    udf_n    = underflow;
    free_n   = free;
    if (flush) begin
      rd_n   = '0;
      wr_n   = '0;
      hist_n = '0;
      ovf_n  = 1'b0;
      udf_n  = 1'b0;
    end else begin
      if (replay_ok)   rd_n = rd_ptr - PW'(1);
      else if (pop_ok) rd_n = rd_ptr + PW'(1);
      if (push_ok)     wr_n = wr_ptr + PW'(1);
      if (wen && !push_ok) ovf_n = 1'b1;
      if (ren && empty && !replay_ok) udf_n = 1'b1;
      hist_sum = hist + PW'(pop_ok) - PW'(replay_ok);
      // Pushes consume the oldest history slots first.
      free_n = PW'(DEPTH) - (wr_n - rd_n);
      hist_n = (hist_sum > free_n) ? free_n : hist_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      hist      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_n;
      hist      <= hist_n;
      overflow  <= ovf_n;
      underflow <= udf_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_issue_fifo_param.sv
// Directed self-checking bench for issue_fifo_param (default build).
// Checks reset, show-ahead, flags, wrap, flush and underflow.
module tb_issue_fifo_param;

  localparam int W = 21;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         wen = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ren = 1'b0;
  logic [W-1:0] data_out, data_out_pre;
  logic         pre_valid, full, almost_full, empty;
  logic         overflow, underflow;
  logic [5:0]   count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  issue_fifo_param dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(data_out), .data_out_pre(data_out_pre),
    .pre_valid(pre_valid), .count(count), .full(full),
    .almost_full(almost_full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w, input logic [W-1:0] d,
                      input logic r, input logic f);
    wen = w; data_in = d; ren = r; flush = f;
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int af_first, f_first;
    logic [W-1:0] exp_head;
    af_first = -1;
    f_first  = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_flags", {30'b0, overflow, underflow}, 0);
    chk("rst_prev", 32'(pre_valid), 0);
    chk("rst_dout", 32'(data_out), 0);

    // single push / pop
    step(1, 21'h1A5, 0, 0);
    chk("t1_dout", 32'(data_out), 32'h1A5);
    chk("t1_count", 32'(count), 1);
    chk("t1_empty", 32'(empty), 0);
    step(0, 0, 1, 0);
    chk("t1_empty2", 32'(empty), 1);
    chk("t1_pre", 32'(data_out_pre), 32'h1A5);
    chk("t1_prev", 32'(pre_valid), 1);

    // fill to DEPTH, watch thresholds
    for (int i = 0; i < D; i++) begin
      step(1, W'(i), 0, 0);
      if (full && f_first < 0) f_first = i + 1;
      if (almost_full && af_first < 0) af_first = i + 1;
    end
    chk("t2_count", 32'(count), 32);
    chk("t2_full_at", 32'(f_first), 29);
    chk("t2_afull_at", 32'(af_first), 25);
    chk("t2_prev_clr", 32'(pre_valid), 0);
    chk("t2_pre_word", 32'(data_out_pre), 31);
    step(1, 21'h55, 0, 0);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_count2", 32'(count), 32);
    chk("t2_head", 32'(data_out), 0);

    // flush beats a same-cycle push; memory kept
    step(1, 21'h3FF, 1, 1);
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_flags", {30'b0, overflow, underflow}, 0);
    chk("t5_prev", 32'(pre_valid), 0);
    chk("t5_mem0", 32'(data_out), 31);

    // steady-state pop+push across pointer wrap
    for (int i = 0; i < 20; i++) step(1, W'(100 + i), 0, 0);
    for (int j = 0; j < 40; j++) begin
      exp_head = (j < 20) ? W'(100 + j) : W'(200 + j - 20);
      chk("t3_head", 32'(data_out), 32'(exp_head));
      step(1, W'(200 + j), 1, 0);
      chk("t3_count", 32'(count), 20);
    end
    chk("t3_flags", {29'b0, overflow, underflow, full}, 0);
    chk("t3_afull", 32'(almost_full), 0);

    // pop on empty with push: no bypass
    step(0, 0, 0, 1);
    step(1, 21'h7, 1, 0);
    chk("t4_udf", 32'(underflow), 1);
    chk("t4_count", 32'(count), 1);
    chk("t4_dout", 32'(data_out), 7);
    chk("t4_ovf", 32'(overflow), 0);

    // asynchronous reset mid-operation
    step(1, 21'h9, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_udf", 32'(underflow), 0);
    chk("ar_dout", 32'(data_out), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
